// File: rtl/tomasulo_pkg.sv
// ============================================================================
// Module      : tomasulo_pkg
// Description : Shared types and constants for the instruction fetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tomasulo_pkg;

    localparam int XLEN      = 32;
    localparam int IFQ_DEPTH = 8;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instruction;
    } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module      : inst_fetch_queue
// Description : Circular FWFT queue of {pc, instruction} pairs, fetch -> dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
    parameter int XLEN  = tomasulo_pkg::XLEN,
    parameter int DEPTH = tomasulo_pkg::IFQ_DEPTH
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     flush,
    input  wire logic                     wr_en,
    input  wire logic [XLEN-1:0]          wr_instruction,
    input  wire logic [XLEN-1:0]          wr_pc,
    output logic                          full,
    input  wire logic                     ifq_rd_en,
    output logic [XLEN-1:0]               instruction,
    output logic [XLEN-1:0]               pc,
    output logic                          valid,
    output logic [$clog2(DEPTH):0]        count
);

    import tomasulo_pkg::*;

    localparam int            AW          = $clog2(DEPTH);
    localparam logic [AW:0]   C_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE   = AW'(1);

    ifq_entry_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic              w_full;
    logic              w_valid;
    logic              w_push;
    logic              w_pop;
    ifq_entry_t        w_head;
    ifq_entry_t        w_wr_entry;

    // Full/empty come from the occupancy counter only, so pointers may wrap freely.
    assign w_full  = (r_count == C_DEPTH);
    assign w_valid = (r_count != '0);

    assign w_push = rst && !flush && wr_en && !w_full;
    assign w_pop  = rst && !flush && ifq_rd_en && w_valid;

    assign w_wr_entry.pc          = wr_pc;
    assign w_wr_entry.instruction = wr_instruction;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // Storage carries no reset; stale contents are hidden by the output mux.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign instruction = w_valid ? w_head.instruction : NOP_INSTR;
    assign pc          = w_valid ? w_head.pc          : '0;
    assign valid       = w_valid;
    assign full        = w_full;
    assign count       = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// Module      : tb_inst_fetch_queue
// Description : Directed bench for inst_fetch_queue against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_fetch_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic [XLEN-1:0]   wr_instruction = '0;
    logic [XLEN-1:0]   wr_pc = '0;
    logic              ifq_rd_en = 1'b0;
    logic              full;
    logic [XLEN-1:0]   instruction;
    logic [XLEN-1:0]   pc;
    logic              valid;
    logic [3:0]        count;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    // Model: entries as {pc, instruction}, oldest at the front.
    logic [63:0] model_q[$];

    inst_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .wr_en          (wr_en),
        .wr_instruction (wr_instruction),
        .wr_pc          (wr_pc),
        .full           (full),
        .ifq_rd_en      (ifq_rd_en),
        .instruction    (instruction),
        .pc             (pc),
        .valid          (valid),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model across the edge, settle.
    task automatic step(input logic r, input logic f, input logic we,
                        input logic [31:0] p, input logic [31:0] ins, input logic re);
        bit push_ok;
        bit pop_ok;
        rst = r; flush = f; wr_en = we; wr_pc = p; wr_instruction = ins; ifq_rd_en = re;
        @(posedge clk);
        if (!r || f) begin
            model_q.delete();
        end else begin
            push_ok = we && (model_q.size() < DEPTH);
            pop_ok  = re && (model_q.size() > 0);
            if (pop_ok)  void'(model_q.pop_front());
            if (push_ok) model_q.push_back({p, ins});
        end
        #1;
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; ifq_rd_en = 1'b0;
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] ins);
        step(1'b1, 1'b0, 1'b1, p, ins, 1'b0);
    endtask

    task automatic pop();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    always @(negedge clk) begin
        if (chk) begin
            logic [63:0] hd;
            hd = (model_q.size() > 0) ? model_q[0] : {32'h0, NOP};
            check("cyc_count", 64'(count), 64'(model_q.size()));
            check("cyc_valid", 64'(valid), 64'(model_q.size() != 0));
            check("cyc_full",  64'(full),  64'(model_q.size() == DEPTH));
            check("cyc_pc",    64'(pc),    64'(hd[63:32]));
            check("cyc_instr", 64'(instruction), 64'(hd[31:0]));
        end
    end

    initial begin
        // 1: reset then idle
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk = 1'b1;
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_full",  64'(full),  64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_instr", 64'(instruction), 64'h13);
        check("rst_pc",    64'(pc),    64'd0);

        // 2: fill and drain
        for (int i = 0; i < 8; i++) push(32'h100 + 4*i, 32'hA000 + i);
        check("fill_full",  64'(full),  64'd1);
        check("fill_count", 64'(count), 64'd8);
        push(32'h200, 32'hDEAD);
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_model", 64'(model_q.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check("drain_pc",    64'(pc),          64'(32'h100 + 4*i));
            check("drain_instr", 64'(instruction), 64'(32'hA000 + i));
            pop();
        end
        check("drain_valid", 64'(valid), 64'd0);

        // 3: wrap-around
        for (int i = 0; i < 6; i++) push(32'h100 + 4*i, 32'hA000 + i);
        for (int i = 0; i < 5; i++) pop();
        for (int i = 0; i < 6; i++) push(32'h400 + 4*i, 32'hB000 + i);
        check("wrap_count", 64'(count), 64'd7);
        check("wrap_head",  64'(pc),    64'h114);
        pop();
        for (int i = 0; i < 6; i++) begin
            check("wrap_pc", 64'(pc), 64'(32'h400 + 4*i));
            pop();
        end

        // 4: simultaneous push + pop at mid, empty and full occupancy
        for (int i = 0; i < 3; i++) push(32'h500 + 4*i, 32'hC000 + i);
        step(1'b1, 1'b0, 1'b1, 32'h50C, 32'hC003, 1'b1);
        check("pp_mid_count", 64'(count), 64'd3);
        check("pp_mid_head",  64'(pc),    64'h504);
        for (int i = 0; i < 3; i++) pop();
        step(1'b1, 1'b0, 1'b1, 32'h600, 32'hD000, 1'b1);
        check("pp_empty_count", 64'(count), 64'd1);
        check("pp_empty_pc",    64'(pc),    64'h600);
        pop();
        for (int i = 0; i < 8; i++) push(32'h700 + 4*i, 32'hE000 + i);
        step(1'b1, 1'b0, 1'b1, 32'h7FC, 32'hEEEE, 1'b1);
        check("pp_full_count", 64'(count), 64'd7);
        check("pp_full_full",  64'(full),  64'd0);
        for (int i = 1; i < 8; i++) begin
            check("pp_full_pc", 64'(pc), 64'(32'h700 + 4*i));
            pop();
        end
        check("pp_full_end", 64'(valid), 64'd0);

        // 5: flush mid-stream with push and pop in the same cycle
        for (int i = 0; i < 5; i++) push(32'h900 + 4*i, 32'hF000 + i);
        step(1'b1, 1'b1, 1'b1, 32'h9FC, 32'hFFFF, 1'b1);
        check("fl_count", 64'(count), 64'd0);
        check("fl_valid", 64'(valid), 64'd0);
        check("fl_instr", 64'(instruction), 64'h13);
        check("fl_pc",    64'(pc), 64'd0);
        push(32'h300, 32'h1234);
        check("fl_push_pc", 64'(pc), 64'h300);
        pop();

        // 6: reset mid-operation, then pop on empty
        for (int i = 0; i < 4; i++) push(32'hA00 + 4*i, 32'h5000 + i);
        step(1'b0, 1'b0, 1'b1, 32'h999, 32'h9999, 1'b0);
        check("mr_count", 64'(count), 64'd0);
        pop();
        check("mr_pop_count", 64'(count), 64'd0);
        push(32'h800, 32'h4444);
        check("mr_push_pc",    64'(pc),          64'h800);
        check("mr_push_instr", 64'(instruction), 64'h4444);
        check("mr_push_count", 64'(count),       64'd1);

        @(negedge clk);
        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Circular FIFO of fetched {pc, instruction} pairs between the fetch stage and the dispatch unit.
- Fetch pushes one entry per cycle; dispatch pops the head with ifq_rd_en when it does not stall.
- Head entry is presented first-word-fall-through.
- flush empties the queue on branch mispredict or exception redirect.

Parameters:
- XLEN, 32, width of instruction and pc.
- DEPTH, 8, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low; asserted when 0, sampled on rising clk.
- flush  in  1  discard all entries this edge.
- wr_en  in  1  fetch push request.
- wr_instruction  in  XLEN  instruction to push.
- wr_pc  in  XLEN  pc of pushed instruction.
- full  out  1  no free entry; registered.
- ifq_rd_en  in  1  dispatch pop of the head entry.
- instruction  out  XLEN  head instruction; NOP when empty.
- pc  out  XLEN  head pc; 0 when empty.
- valid  out  1  head entry present (not empty).
- count  out  AW+1  occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst==0 at edge): wr_ptr=0, rd_ptr=0, count=0, full=0, valid=0, instruction=32'h00000013 (addi x0,x0,0), pc=0. Storage contents are don't-care.
- Priority at each edge: reset > flush > push/pop.
- Flush: pointers and count return to 0, full=0, valid=0. Any push or pop in the same cycle is dropped. Output is NOP/0 from the next cycle.
- Push is accepted iff wr_en && !full. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Push while full is ignored silently, with no overwrite. Fetch must hold the entry and retry.
- Pop is accepted iff ifq_rd_en && valid, and rd_ptr increments modulo DEPTH. Pop while empty is ignored, with no pointer or count change.
- Push and pop in the same cycle:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: only the push is accepted. There is no bypass, so the new entry appears at the outputs one cycle later.
  - Full: only the pop is accepted. full is registered, so the write is refused and full deasserts next cycle.
- count updates as +1, -1 or 0 per accepted ops. full = (count==DEPTH) and valid = (count!=0), both derived from the registered count.
- Output latency:
  - instruction/pc reflect storage at rd_ptr combinationally from registered state.
  - A push becomes visible at the head one cycle after acceptance.
  - A pop exposes the next entry in the same cycle the pointer advances (after the edge).
- Wrap-around: pointers are AW bits and wrap naturally. Full/empty are resolved by count, never by pointer compare.
- No X on the outputs after reset regardless of storage contents: the outputs are muxed to NOP/0 when !valid.

Decomposition:
- Shared package tomasulo_pkg holds:
  - XLEN.
  - IFQ_DEPTH (default 8).
  - NOP_INSTR = 32'h00000013.
  - Packed struct ifq_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instruction;}.
- Storage is an array of ifq_entry_t inside the module. No sub-module is warranted; pointer and count logic stay inline.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles, then 1 → valid=0, full=0, count=0, instruction=32'h00000013, pc=0.
2. Fill and drain: push 8 entries with pc=0x100+4i and instruction=0xA000+i → full=1 and count=8 after the 8th. A 9th push (pc=0x200) is ignored. Pop 8 → the head sequence is pc 0x100..0x11C in order, then valid=0.
3. Wrap-around:
   - Push 6, pop 5, push 6 (wr_ptr wraps) → count=7.
   - Pops return the 6th original entry (pc 0x114), then the new entries in order.
4. Simultaneous push+pop:
   - At count=3 → count stays 3 and the head advances.
   - At count=0 → after the edge count=1, and the pushed entry is visible at the outputs.
   - At count=8 → count=7, full=0, and the pushed entry is absent.
5. Flush mid-stream: with count=5, assert flush together with wr_en and ifq_rd_en → next cycle count=0, valid=0, outputs NOP/0. A subsequent push (pc=0x300) becomes the head.
6. Reset mid-operation: with count=4, drive rst=0 in the same cycle as wr_en → count=0, and the pushed entry is discarded. Pop while empty leaves count=0 and rd_ptr unchanged (next push appears at the head).
